sys1_io_hub: RTL and testbench

- Parametrised main-CPU I/O unit for the System 1 core.
- Replaces ad-hoc port decode with a single clocked block. It provides:
  - N joystick/input ports and DIP-switch reads.
  - A latched video-mode register.
  - A buffered sound-command queue with handshake.
  - An edge-latched VBLANK interrupt with acknowledge.
  - A readable status port.
- Sits between the Z80 bus signals and the main CPU data-input selector. Runs on the 48 MHz system clock, with CPU strobes sampled as levels.

---
 rtl/sys1_io_hub_if.sv | 34 +++
 rtl/sys1_io_hub.sv | 167 ++++++++++++++++
 tb/tb_sys1_io_hub.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sys1_io_hub_if.sv
`default_nettype none
// ============================================================================
//  Module  : sys1_io_hub_if
//  Brief   : Z80 I/O bus and sound-command handshake bundle for sys1_io_hub.
//            master = CPU / sound side, slave = the I/O hub.
//  Rev     : 1.0  initial release
// ============================================================================
interface sys1_io_hub_if;
  // CPU bus cycle
  logic       IORQ;
  logic       RD;
  logic       WR;
  logic       M1;
  logic [4:0] AD;
  logic [7:0] DI;
  // Registered read return
  logic       IOCS;
  logic [7:0] IODO;
  // Sound-command queue handshake
  logic [7:0] SNDDT;
  logic       SNDVLD;
  logic       SNDACK;

  modport master (
    output IORQ, RD, WR, M1, AD, DI, SNDACK,
    input  IOCS, IODO, SNDDT, SNDVLD
  );

  modport slave (
    input  IORQ, RD, WR, M1, AD, DI, SNDACK,
    output IOCS, IODO, SNDDT, SNDVLD
  );
endinterface
`default_nettype wire

// File: rtl/sys1_io_hub.sv
`default_nettype none
// ============================================================================
//  Module  : sys1_io_hub
//  Brief   : Main-CPU I/O unit: input/DIP port reads, video-mode latch,
//            sound-command FIFO with handshake, VBLANK interrupt, status port.
//  Rev     : 1.0  initial release
// ============================================================================
module sys1_io_hub #(
  parameter int         NUM_INP    = 3,
  parameter int         SNDQ_DEPTH = 4,
  parameter logic [4:0] VID_PORT   = 5'h19,
  parameter logic [4:0] SND_PORT   = 5'h18,
  parameter logic [4:0] STAT_PORT  = 5'h1A
) (
  input  logic                 CLK48M,
  input  logic                 RESET,
  sys1_io_hub_if.slave         bus,
  input  logic [NUM_INP*8-1:0] INP,
  input  logic [7:0]           DSW0,
  input  logic [7:0]           DSW1,
  input  logic                 VBLK,
  output logic [7:0]           VIDMODE,
  output logic                 INTRQ,
  output logic                 SNDOVF
);

  localparam int c_ptr_w = $clog2(SNDQ_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_ptr_w-1:0] c_ptr_one = 1;
  localparam logic [c_cnt_w-1:0] c_cnt_one = 1;
  localparam logic [c_cnt_w-1:0] c_depth   = SNDQ_DEPTH[c_cnt_w-1:0];

  // Registered state
  logic               rd_lvl_q, wr_lvl_q, ack_lvl_q, vblk_q;
  logic               iocs_q, intrq_q, ovf_q;
  logic [7:0]         iodo_q, vid_q;
  logic [c_ptr_w-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_cnt_w-1:0] count_q;
  logic [7:0]         mem_q [SNDQ_DEPTH];

  // Next-state values
  logic               rd_lvl_d, wr_lvl_d, ack_lvl_d, vblk_d;
  logic               iocs_d, intrq_d, ovf_d;
  logic [7:0]         iodo_d, vid_d;
  logic [c_ptr_w-1:0] wr_ptr_d, rd_ptr_d;
  logic [c_cnt_w-1:0] count_d;
  logic [7:0]         mem_d [SNDQ_DEPTH];

  // Combinational helpers
  logic       w_rd_pulse, w_wr_pulse, w_ack_pulse, w_vblk_rise;
  logic       w_push_req, w_push, w_pop, w_full;
  logic       w_sel_ok;
  logic [7:0] w_sel_dat;
  logic [7:0] w_inp [4];

  // Input ports as a fixed 4-entry table; slots beyond NUM_INP are never selected
  for (genvar k = 0; k < 4; k++) begin : g_inp
    if (k < NUM_INP) begin : g_map
      assign w_inp[k] = INP[8*k +: 8];
    end else begin : g_unmap
      assign w_inp[k] = 8'hFF;
    end
  end

  // Bus decode, edge detection, FIFO and interrupt next-state logic
  always_comb begin
    rd_lvl_d  = bus.IORQ & bus.RD & ~bus.M1;
    wr_lvl_d  = bus.IORQ & bus.WR & ~bus.M1;
    ack_lvl_d = bus.IORQ & bus.M1;
    vblk_d    = VBLK;

    w_rd_pulse  = rd_lvl_d  & ~rd_lvl_q;
    w_wr_pulse  = wr_lvl_d  & ~wr_lvl_q;
    w_ack_pulse = ack_lvl_d & ~ack_lvl_q;
    w_vblk_rise = VBLK & ~vblk_q;

    // Read mux: input ports take precedence over the DIP group when NUM_INP=4
    w_sel_ok  = 1'b1;
    w_sel_dat = 8'hFF;
    if (32'(bus.AD[4:2]) < NUM_INP) begin
      w_sel_dat = w_inp[bus.AD[3:2]];
    end else if (bus.AD[4:2] == 3'd3) begin
      w_sel_dat = bus.AD[0] ? DSW1 : DSW0;
    end else if (bus.AD == 5'h10) begin
      w_sel_dat = DSW1;
    end else if (bus.AD == STAT_PORT) begin
      w_sel_dat = {ovf_q, intrq_q, VBLK, 5'(count_q)};
    end else begin
      w_sel_ok  = 1'b0;
    end
    iocs_d = rd_lvl_d & w_sel_ok;
    iodo_d = (rd_lvl_d & w_sel_ok) ? w_sel_dat : 8'hFF;

    vid_d = vid_q;
    if (w_wr_pulse && bus.AD == VID_PORT) vid_d = bus.DI;

    // A pop in the same clock frees the slot, so a push into a full queue
    // is only rejected when no pop accompanies it
    w_full     = (count_q == c_depth);
    w_pop      = bus.SNDACK & (count_q != '0);
    w_push_req = w_wr_pulse & (bus.AD == SND_PORT);
    w_push     = w_push_req & (~w_full | w_pop);

    mem_d = mem_q;
    if (w_push) mem_d[wr_ptr_q] = bus.DI;
    wr_ptr_d = w_push ? wr_ptr_q + c_ptr_one : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + c_ptr_one : rd_ptr_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase

    // Status read clears the sticky flag once per bus cycle; a fresh overflow wins
    ovf_d = ovf_q;
    if (w_rd_pulse && bus.AD == STAT_PORT) ovf_d = 1'b0;
    if (w_push_req && !w_push)             ovf_d = 1'b1;

    // Interrupt: a VBLANK edge in the same clock as an acknowledge keeps it set
    intrq_d = intrq_q;
    if (w_ack_pulse) intrq_d = 1'b0;
    if (w_vblk_rise) intrq_d = 1'b1;
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      rd_lvl_q  <= 1'b0;
      wr_lvl_q  <= 1'b0;
      ack_lvl_q <= 1'b0;
      vblk_q    <= 1'b0;
      iocs_q    <= 1'b0;
      iodo_q    <= 8'hFF;
      vid_q     <= 8'h00;
      intrq_q   <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < SNDQ_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      rd_lvl_q  <= rd_lvl_d;
      wr_lvl_q  <= wr_lvl_d;
      ack_lvl_q <= ack_lvl_d;
      vblk_q    <= vblk_d;
      iocs_q    <= iocs_d;
      iodo_q    <= iodo_d;
      vid_q     <= vid_d;
      intrq_q   <= intrq_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  assign bus.IOCS   = iocs_q;
  assign bus.IODO   = iodo_q;
  assign bus.SNDDT  = mem_q[rd_ptr_q];
  assign bus.SNDVLD = (count_q != '0);
  assign VIDMODE    = vid_q;
  assign INTRQ      = intrq_q;
  assign SNDOVF     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sys1_io_hub.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sys1_io_hub
//  Brief   : Self-checking bench for sys1_io_hub: queue-based reference model
//            compared every cycle, plus directed literal expectations.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_sys1_io_hub;
  localparam int NUM_INP = 3;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] inp  = {8'h33, 8'h5A, 8'hC3};
  logic [7:0]  dsw0 = 8'hA5;
  logic [7:0]  dsw1 = 8'h3C;
  logic        vblk = 1'b0;
  logic [7:0]  vidmode;
  logic        intrq, sndovf;

  always #5 clk = ~clk;

  sys1_io_hub_if bus();

  sys1_io_hub #(
    .NUM_INP(NUM_INP), .SNDQ_DEPTH(DEPTH),
    .VID_PORT(5'h19), .SND_PORT(5'h18), .STAT_PORT(5'h1A)
  ) dut (
    .CLK48M(clk), .RESET(rst), .bus(bus), .INP(inp), .DSW0(dsw0), .DSW1(dsw1),
    .VBLK(vblk), .VIDMODE(vidmode), .INTRQ(intrq), .SNDOVF(sndovf)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mq[$];
  bit         m_ovf, m_intrq, m_iocs;
  logic [7:0] m_vid, m_iodo;
  bit         p_rd, p_wr, p_ack, p_vblk;

  function automatic void decode(input logic [4:0] ad, output bit ok, output logic [7:0] d);
    int port = int'(ad) / 4;
    ok = 1'b1;
    if (port < NUM_INP)    d = inp[port*8 +: 8];
    else if (port == 3)    d = ad[0] ? dsw1 : dsw0;
    else if (ad == 5'h10)  d = dsw1;
    else if (ad == 5'h1A)  d = {m_ovf, m_intrq, vblk, 5'(mq.size())};
    else begin ok = 1'b0;  d = 8'hFF; end
  endfunction

  always @(posedge clk) begin
    bit rdl, wrl, ackl, ok;
    logic [7:0] d;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_intrq = 0; m_iocs = 0; m_vid = 8'h00; m_iodo = 8'hFF;
      p_rd = 0; p_wr = 0; p_ack = 0; p_vblk = 0;
    end else begin
      rdl  = bus.IORQ && bus.RD && !bus.M1;
      wrl  = bus.IORQ && bus.WR && !bus.M1;
      ackl = bus.IORQ && bus.M1;
      decode(bus.AD, ok, d);
      m_iocs = rdl && ok;
      m_iodo = (rdl && ok) ? d : 8'hFF;
      if (rdl && !p_rd && bus.AD == 5'h1A) m_ovf = 0;
      if (bus.SNDACK && mq.size() > 0) void'(mq.pop_front());
      if (wrl && !p_wr && bus.AD == 5'h18) begin
        if (mq.size() < DEPTH) mq.push_back(bus.DI);
        else m_ovf = 1;
      end
      if (wrl && !p_wr && bus.AD == 5'h19) m_vid = bus.DI;
      if (ackl && !p_ack) m_intrq = 0;
      if (vblk && !p_vblk) m_intrq = 1;
      p_rd = rdl; p_wr = wrl; p_ack = ackl; p_vblk = vblk;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_iocs",    8'(bus.IOCS), 8'(m_iocs));
      chk("m_iodo",    bus.IODO,     m_iodo);
      chk("m_vidmode", vidmode,      m_vid);
      chk("m_intrq",   8'(intrq),    8'(m_intrq));
      chk("m_sndovf",  8'(sndovf),   8'(m_ovf));
      chk("m_sndvld",  8'(bus.SNDVLD), 8'(mq.size() != 0));
      if (mq.size() != 0) chk("m_snddt", bus.SNDDT, mq[0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [4:0] ad, output logic cs, output logic [7:0] d);
    bus.IORQ = 1; bus.RD = 1; bus.AD = ad;
    cyc(1);
    cs = bus.IOCS; d = bus.IODO;
    bus.IORQ = 0; bus.RD = 0;
    cyc(1);
  endtask

  task automatic do_write(input logic [4:0] ad, input logic [7:0] d);
    bus.IORQ = 1; bus.WR = 1; bus.AD = ad; bus.DI = d;
    cyc(1);
    bus.IORQ = 0; bus.WR = 0;
    cyc(1);
  endtask

  task automatic ack_snd;
    bus.SNDACK = 1;
    cyc(1);
    bus.SNDACK = 0;
  endtask

  initial begin
    logic       cs;
    logic [7:0] d;
    logic [7:0] exp4 [4];
    bus.IORQ = 0; bus.RD = 0; bus.WR = 0; bus.M1 = 0;
    bus.AD = 5'h00; bus.DI = 8'h00; bus.SNDACK = 0;

    // reset then idle
    cyc(1);
    cmp_en = 1'b1;
    rst = 1'b0;
    cyc(4);
    chk("rst_vidmode", vidmode, 8'h00);
    chk("rst_iodo",    bus.IODO, 8'hFF);
    chk("rst_iocs",    8'(bus.IOCS), 8'h00);
    chk("rst_intrq",   8'(intrq), 8'h00);
    chk("rst_sndvld",  8'(bus.SNDVLD), 8'h00);
    chk("rst_snddt",   bus.SNDDT, 8'h00);

    // port reads
    do_read(5'h04, cs, d); chk("inp1_cs", 8'(cs), 8'h01); chk("inp1", d, 8'h5A);
    do_read(5'h00, cs, d); chk("inp0", d, 8'hC3);
    do_read(5'h0D, cs, d); chk("dsw1_0d", d, 8'h3C);
    do_read(5'h0C, cs, d); chk("dsw0_0c", d, 8'hA5);
    do_read(5'h10, cs, d); chk("dsw1_10", d, 8'h3C);
    do_read(5'h1F, cs, d); chk("unmap_cs", 8'(cs), 8'h00); chk("unmap_do", d, 8'hFF);

    // long write strobe yields exactly one push
    bus.IORQ = 1; bus.WR = 1; bus.AD = 5'h18; bus.DI = 8'h21;
    cyc(16);
    bus.IORQ = 0; bus.WR = 0;
    cyc(1);
    chk("hold_vld", 8'(bus.SNDVLD), 8'h01);
    chk("hold_dt",  bus.SNDDT, 8'h21);
    do_read(5'h1A, cs, d); chk("hold_stat", d, 8'h01);
    ack_snd;
    chk("hold_drained", 8'(bus.SNDVLD), 8'h00);

    // overflow: five pushes into depth four
    for (int i = 1; i <= 5; i++) do_write(5'h18, 8'(i));
    chk("ovf_set", 8'(sndovf), 8'h01);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_seq", bus.SNDDT, 8'(i));
      ack_snd;
    end
    chk("ovf_empty", 8'(bus.SNDVLD), 8'h00);
    do_read(5'h1A, cs, d); chk("ovf_stat", d, 8'h80);
    chk("ovf_cleared", 8'(sndovf), 8'h00);

    // full queue with simultaneous push and pop
    for (int i = 0; i < 4; i++) do_write(5'h18, 8'(8'h10 + i));
    bus.IORQ = 1; bus.WR = 1; bus.AD = 5'h18; bus.DI = 8'hAA; bus.SNDACK = 1;
    cyc(1);
    bus.IORQ = 0; bus.WR = 0; bus.SNDACK = 0;
    cyc(1);
    do_read(5'h1A, cs, d); chk("pp_stat", d, 8'h04);
    chk("pp_noovf", 8'(sndovf), 8'h00);
    exp4 = '{8'h11, 8'h12, 8'h13, 8'hAA};
    for (int i = 0; i < 4; i++) begin
      chk("pp_seq", bus.SNDDT, exp4[i]);
      ack_snd;
    end

    // video mode
    do_write(5'h19, 8'h5C); chk("vid", vidmode, 8'h5C);

    // interrupt
    vblk = 1; cyc(1); chk("int_set", 8'(intrq), 8'h01);
    vblk = 0; cyc(2); chk("int_hold", 8'(intrq), 8'h01);
    do_read(5'h1A, cs, d); chk("int_stat", d, 8'h40);
    bus.IORQ = 1; bus.M1 = 1; cyc(1); chk("int_ack", 8'(intrq), 8'h00);
    bus.IORQ = 0; bus.M1 = 0; cyc(1);
    vblk = 1; bus.IORQ = 1; bus.M1 = 1; cyc(1); chk("int_setwins", 8'(intrq), 8'h01);
    bus.IORQ = 0; bus.M1 = 0; vblk = 0; cyc(1);

    // reset mid-operation
    do_write(5'h18, 8'h77);
    rst = 1; cyc(1);
    chk("rst2_intrq",  8'(intrq), 8'h00);
    chk("rst2_sndvld", 8'(bus.SNDVLD), 8'h00);
    chk("rst2_vid",    vidmode, 8'h00);
    rst = 0; cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
